match_search_arbiter: RTL and testbench

- Shares one pattern-match engine (search fsm + compare datapath, 9-bit address space) among NUM_REQ requesters.
- Round-robin grants one requester at a time, issues the engine start pulse, sequences the address sweep, captures the match location or declares a miss, and returns the result over a valid/ready handshake.
- Sits between requester clients and the engine's start / done_flag / match_address interface.

---
 rtl/match_search_arbiter.sv | 178 +++++++++++++++++
 tb/tb_match_search_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/match_search_arbiter.sv
// Round-robin arbiter sharing one pattern-match engine among NUM_REQ requesters.
// Optional SEARCH_STATS_EN adds saturating search/miss counters.
module match_search_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          ID_W     = 2,
    parameter logic [8:0]  MAX_ADDR = 9'd511
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               eng_start,
    output logic               eng_inc,
    output logic [8:0]         eng_addr,
    input  logic               eng_done,
    input  logic [8:0]         eng_match_address,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_found,
    output logic [8:0]         rsp_location
`ifdef SEARCH_STATS_EN
    ,
    output logic [15:0]        stat_searches,
    output logic [15:0]        stat_misses
`endif
);

    typedef enum logic [1:0] {IDLE, START, SWEEP, RESP} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
    logic               r_eng_start, w_eng_start_nxt;
    logic               r_eng_inc, w_eng_inc_nxt;
    logic [8:0]         r_eng_addr, w_eng_addr_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [ID_W-1:0]    r_rsp_id, w_rsp_id_nxt;
    logic               r_rsp_found, w_rsp_found_nxt;
    logic [8:0]         r_rsp_location, w_rsp_location_nxt;

    logic               w_win_vld;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_win_inc;
    logic               w_req_own;
    logic               w_accept;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_win_vld && req[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_win_vld = 1'b1;
                w_win     = ID_W'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_win_inc = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_req_own = |(req & r_grant);
    assign w_accept  = (r_state == RESP) && r_rsp_valid && rsp_ready;

    always_comb begin
        w_state_nxt        = r_state;
        w_grant_nxt        = r_grant;
        w_ptr_nxt          = r_ptr;
        w_eng_start_nxt    = 1'b0;
        w_eng_inc_nxt      = r_eng_inc;
        w_eng_addr_nxt     = r_eng_addr;
        w_rsp_valid_nxt    = r_rsp_valid;
        w_rsp_id_nxt       = r_rsp_id;
        w_rsp_found_nxt    = r_rsp_found;
        w_rsp_location_nxt = r_rsp_location;
        unique case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                    w_rsp_id_nxt = w_win;
                    w_ptr_nxt    = w_win_inc;
                    w_state_nxt  = START;
                end
            end
            START: begin
                w_eng_start_nxt = 1'b1;
                w_eng_inc_nxt   = 1'b1;
                w_eng_addr_nxt  = '0;
                w_state_nxt     = SWEEP;
            end
            SWEEP: begin
                // A dropped request abandons the search even if the engine reports now.
                if (!w_req_own) begin
                    w_grant_nxt   = '0;
                    w_eng_inc_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (eng_done) begin
                    w_rsp_location_nxt = eng_match_address;
                    w_rsp_found_nxt    = 1'b1;
                    w_rsp_valid_nxt    = 1'b1;
                    w_eng_inc_nxt      = 1'b0;
                    w_state_nxt        = RESP;
                end else if (r_eng_addr == MAX_ADDR) begin
                    w_rsp_location_nxt = MAX_ADDR;
                    w_rsp_found_nxt    = 1'b0;
                    w_rsp_valid_nxt    = 1'b1;
                    w_eng_inc_nxt      = 1'b0;
                    w_state_nxt        = RESP;
                end else begin
                    w_eng_addr_nxt = r_eng_addr + 9'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_grant_nxt     = '0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_grant        <= '0;
            r_ptr          <= '0;
            r_eng_start    <= 1'b0;
            r_eng_inc      <= 1'b0;
            r_eng_addr     <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_found    <= 1'b0;
            r_rsp_location <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_ptr          <= w_ptr_nxt;
            r_eng_start    <= w_eng_start_nxt;
            r_eng_inc      <= w_eng_inc_nxt;
            r_eng_addr     <= w_eng_addr_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_id       <= w_rsp_id_nxt;
            r_rsp_found    <= w_rsp_found_nxt;
            r_rsp_location <= w_rsp_location_nxt;
        end
    end

`ifdef SEARCH_STATS_EN
    logic [15:0] r_stat_searches, r_stat_misses;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_searches <= '0;
            r_stat_misses   <= '0;
        end else if (w_accept) begin
            if (r_stat_searches != 16'hFFFF) r_stat_searches <= r_stat_searches + 16'd1;
            if (!r_rsp_found && r_stat_misses != 16'hFFFF) r_stat_misses <= r_stat_misses + 16'd1;
        end
    end

    assign stat_searches = r_stat_searches;
    assign stat_misses   = r_stat_misses;
`else
    logic w_accept_unused;
    assign w_accept_unused = w_accept;
`endif

    assign grant        = r_grant;
    assign eng_start    = r_eng_start;
    assign eng_inc      = r_eng_inc;
    assign eng_addr     = r_eng_addr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_found    = r_rsp_found;
    assign rsp_location = r_rsp_location;

endmodule

// File: tb/tb_match_search_arbiter.sv
// Directed bench for match_search_arbiter: hits, misses, round-robin, abort,
// backpressure, coincident done/end-of-sweep, mid-search reset, optional stats.
module tb_match_search_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       eng_start, eng_inc;
    logic [8:0] eng_addr;
    logic       eng_done;
    logic [8:0] eng_match_address;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_id;
    logic       rsp_found;
    logic [8:0] rsp_location;
`ifdef SEARCH_STATS_EN
    logic [15:0] stat_searches, stat_misses;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    match_search_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .grant(grant),
        .eng_start(eng_start), .eng_inc(eng_inc), .eng_addr(eng_addr),
        .eng_done(eng_done), .eng_match_address(eng_match_address),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_found(rsp_found), .rsp_location(rsp_location)
`ifdef SEARCH_STATS_EN
        , .stat_searches(stat_searches), .stat_misses(stat_misses)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_start"}, 32'(eng_start), 0);
        chk({tag, "_inc"},   32'(eng_inc), 0);
        chk({tag, "_addr"},  32'(eng_addr), 0);
        chk({tag, "_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_id"},    32'(rsp_id), 0);
        chk({tag, "_found"}, 32'(rsp_found), 0);
        chk({tag, "_loc"},   32'(rsp_location), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; req = '0; eng_done = 0; rsp_ready = 0; eng_match_address = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Run one search from the current negedge; hit<0 means the engine never reports.
    task automatic do_search(input logic [3:0] r, input int hit, input logic [1:0] exp_id,
                             input logic exp_found, input logic [8:0] exp_loc,
                             input int hold, input logic [3:0] next_req);
        int n;
        req = r;
        n = 0;
        while (grant == 0 && n < 10) begin @(negedge clock); n++; end
        chk("grant", 32'(grant), 32'(1) << exp_id);
        chk("grant_id", 32'(rsp_id), 32'(exp_id));
        chk("start_lat", 32'(eng_start), 0);
        @(negedge clock);
        chk("start", 32'(eng_start), 1);
        chk("sweep_addr0", 32'(eng_addr), 0);
        chk("sweep_inc", 32'(eng_inc), 1);
        n = 0;
        while (!rsp_valid && n < 700) begin
            eng_done = (hit >= 0) && (int'(eng_addr) == hit);
            eng_match_address = 9'(hit);
            @(negedge clock);
            n++;
        end
        eng_done = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
        chk("rsp_found", 32'(rsp_found), 32'(exp_found));
        chk("rsp_loc", 32'(rsp_location), 32'(exp_loc));
        chk("rsp_inc", 32'(eng_inc), 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_loc", 32'(rsp_location), 32'(exp_loc));
            chk("hold_grant", 32'(grant), 32'(1) << exp_id);
        end
        rsp_ready = 1'b1;
        req = next_req;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("acc_valid", 32'(rsp_valid), 0);
        chk("acc_grant", 32'(grant), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0; req = '0; eng_done = 0; rsp_ready = 0; eng_match_address = '0;
        #12;
        chk_idle_outs("reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // single hit at 37, then miss on requester 2
        do_search(4'b0001, 37, 2'd0, 1'b1, 9'd37, 0, 4'b0000);
        do_search(4'b0100, -1, 2'd2, 1'b0, 9'd511, 0, 4'b0000);

        // round-robin from a fresh pointer with all requests held
        do_reset();
        do_search(4'b1111, 3, 2'd0, 1'b1, 9'd3, 0, 4'b1111);
        do_search(4'b1111, 4, 2'd1, 1'b1, 9'd4, 0, 4'b1111);
        do_search(4'b1111, 5, 2'd2, 1'b1, 9'd5, 0, 4'b1111);
        do_search(4'b1111, 6, 2'd3, 1'b1, 9'd6, 0, 4'b1111);
        do_search(4'b1111, 7, 2'd0, 1'b1, 9'd7, 0, 4'b0000);

        // abort: requester 1 drops at address 10
        req = 4'b0010;
        n = 0;
        while (!(eng_inc && eng_addr == 9'd10) && n < 40) begin @(negedge clock); n++; end
        chk("abort_addr", 32'(eng_addr), 10);
        chk("abort_grant_pre", 32'(grant), 32'b0010);
        req = 4'b0000;
        @(negedge clock);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_inc", 32'(eng_inc), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("abort_novalid", 32'(rsp_valid), 0);
        end

        // pointer advanced past 1, so requester 2 wins; then 5 cycles of backpressure
        do_search(4'b0111, 5, 2'd2, 1'b1, 9'd5, 5, 4'b0000);
        // done coincident with last address: found wins
        do_search(4'b0001, 511, 2'd0, 1'b1, 9'd511, 0, 4'b0000);

        // reset mid-sweep at address 100
        req = 4'b0001;
        n = 0;
        while (!(eng_inc && eng_addr == 9'd100) && n < 200) begin @(negedge clock); n++; end
        chk("mid_addr", 32'(eng_addr), 100);
        reset = 1'b0;
        #1;
        chk_idle_outs("midrst");
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_rst_grant", 32'(grant), 0);
            chk("post_rst_valid", 32'(rsp_valid), 0);
        end

        // three hits and one miss (pointer back at 0 after reset)
        do_search(4'b0001, 1, 2'd0, 1'b1, 9'd1, 0, 4'b0000);
        do_search(4'b0010, 2, 2'd1, 1'b1, 9'd2, 0, 4'b0000);
        do_search(4'b1000, -1, 2'd3, 1'b0, 9'd511, 0, 4'b0000);
        do_search(4'b0001, 9, 2'd0, 1'b1, 9'd9, 0, 4'b0000);
`ifdef SEARCH_STATS_EN
        chk("stat_searches", 32'(stat_searches), 4);
        chk("stat_misses", 32'(stat_misses), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
